// File: rtl/ct_cp0_l2csr_req_ctrl.sv
// rtl/ct_cp0_l2csr_req_ctrl.sv - L2C CSR request controller; optional timeout via L2CSR_TIMEOUT_EN
module ct_cp0_l2csr_req_ctrl #(
  parameter int TIMEOUT_W      = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic          coreclk,
  input  logic          cpurst_b,
  input  logic          cp0_l2csr_req_vld,
  input  logic [15:0]   cp0_l2csr_req_op,
  input  logic [63:0]   cp0_l2csr_req_wdata,
  input  logic          cp0_l2csr_flush,
  output logic          l2csr_req_rdy,
  output logic          l2csr_busy,
  output logic          l2csr_rslt_vld,
  output logic [63:0]   l2csr_rslt_data,
  output logic          l2csr_rslt_err,
  output logic          biu_csr_sel,
  output logic [15:0]   biu_csr_op,
  output logic [63:0]   biu_csr_wdata,
  input  logic          biu_csr_cmplt,
  input  logic [127:0]  biu_csr_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t       state;
  logic         abort;
  logic         accept;
  logic         tmo_hit;
  logic [63:0]  cmplt_half;

  // The counter must be able to hold the timeout threshold.
  if (TIMEOUT_CYCLES < 1 || longint'(TIMEOUT_CYCLES) >= (longint'(1) << TIMEOUT_W)) begin : g_bad_timeout_cfg
    $error("TIMEOUT_CYCLES does not fit in TIMEOUT_W bits");
  end

  assign l2csr_req_rdy = (state == IDLE) && !cp0_l2csr_flush;
  assign accept        = cp0_l2csr_req_vld && l2csr_req_rdy;
  assign l2csr_busy    = (state != IDLE);
  assign cmplt_half    = biu_csr_op[15] ? biu_csr_rdata[127:64] : biu_csr_rdata[63:0];

`ifdef L2CSR_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TMO_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);
  localparam logic [TIMEOUT_W-1:0] TMO_MAX   = '1;
  localparam logic [TIMEOUT_W-1:0] TMO_ONE   = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  logic [TIMEOUT_W-1:0] tmo_cnt;

  // Timeout fires on the edge where the counter reaches the limit, once per
  // transaction; a real completion or a flush in that cycle takes precedence.
  assign tmo_hit = (state == WAIT) && !abort && !cp0_l2csr_flush && !biu_csr_cmplt &&
                   (tmo_cnt != TMO_MAX) && ((tmo_cnt + TMO_ONE) == TMO_LIMIT);

  // WAIT-cycle counter: cleared on acceptance, saturating while waiting.
  always_ff @(posedge coreclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      tmo_cnt <= '0;
    end else if (accept) begin
      tmo_cnt <= '0;
    end else if (state == WAIT && tmo_cnt != TMO_MAX) begin
      tmo_cnt <= tmo_cnt + TMO_ONE;
    end
  end

  // Error flag accompanies only the timeout result pulse.
  always_ff @(posedge coreclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      l2csr_rslt_err <= 1'b0;
    end else begin
      l2csr_rslt_err <= tmo_hit;
    end
  end
`else
  assign tmo_hit        = 1'b0;
  assign l2csr_rslt_err = 1'b0;
`endif

  // Request FSM: sel is registered alongside the state so it drops for the
  // whole GAP cycle, giving the BIU edge detector a clean low between requests.
  always_ff @(posedge coreclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state           <= IDLE;
      biu_csr_sel     <= 1'b0;
      biu_csr_op      <= 16'd0;
      biu_csr_wdata   <= 64'd0;
      abort           <= 1'b0;
      l2csr_rslt_vld  <= 1'b0;
      l2csr_rslt_data <= 64'd0;
    end else begin
      l2csr_rslt_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state         <= WAIT;
            biu_csr_sel   <= 1'b1;
            biu_csr_op    <= cp0_l2csr_req_op;
            biu_csr_wdata <= cp0_l2csr_req_wdata;
            abort         <= 1'b0;
          end
        end
        WAIT: begin
          if (biu_csr_cmplt) begin
            state           <= GAP;
            biu_csr_sel     <= 1'b0;
            l2csr_rslt_data <= cmplt_half;
            l2csr_rslt_vld  <= !abort && !cp0_l2csr_flush;
          end else if (tmo_hit) begin
            l2csr_rslt_vld  <= 1'b1;
            l2csr_rslt_data <= 64'd0;
            abort           <= 1'b1;
          end else if (cp0_l2csr_flush) begin
            abort <= 1'b1;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state       <= IDLE;
          biu_csr_sel <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ct_cp0_l2csr_req_ctrl.sv
// tb/tb_ct_cp0_l2csr_req_ctrl.sv - self-checking bench for ct_cp0_l2csr_req_ctrl
module tb_ct_cp0_l2csr_req_ctrl;

  logic          coreclk = 1'b0;
  logic          cpurst_b = 1'b0;
  logic          cp0_l2csr_req_vld = 1'b0;
  logic [15:0]   cp0_l2csr_req_op = '0;
  logic [63:0]   cp0_l2csr_req_wdata = '0;
  logic          cp0_l2csr_flush = 1'b0;
  logic          l2csr_req_rdy;
  logic          l2csr_busy;
  logic          l2csr_rslt_vld;
  logic [63:0]   l2csr_rslt_data;
  logic          l2csr_rslt_err;
  logic          biu_csr_sel;
  logic [15:0]   biu_csr_op;
  logic [63:0]   biu_csr_wdata;
  logic          biu_csr_cmplt = 1'b0;
  logic [127:0]  biu_csr_rdata = '0;

  always #5 coreclk = ~coreclk;

  ct_cp0_l2csr_req_ctrl #(.TIMEOUT_W(16), .TIMEOUT_CYCLES(8)) u_dut (
    .coreclk             (coreclk),
    .cpurst_b            (cpurst_b),
    .cp0_l2csr_req_vld   (cp0_l2csr_req_vld),
    .cp0_l2csr_req_op    (cp0_l2csr_req_op),
    .cp0_l2csr_req_wdata (cp0_l2csr_req_wdata),
    .cp0_l2csr_flush     (cp0_l2csr_flush),
    .l2csr_req_rdy       (l2csr_req_rdy),
    .l2csr_busy          (l2csr_busy),
    .l2csr_rslt_vld      (l2csr_rslt_vld),
    .l2csr_rslt_data     (l2csr_rslt_data),
    .l2csr_rslt_err      (l2csr_rslt_err),
    .biu_csr_sel         (biu_csr_sel),
    .biu_csr_op          (biu_csr_op),
    .biu_csr_wdata       (biu_csr_wdata),
    .biu_csr_cmplt       (biu_csr_cmplt),
    .biu_csr_rdata       (biu_csr_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Outputs sampled at the falling edge of the current step.
  logic         s_sel, s_busy, s_rdy, s_vld, s_err;
  logic [63:0]  s_data, s_wdata;
  logic [15:0]  s_op;

  // Reference model: one outstanding-transaction record plus the number of
  // cycles since the last completion (the result appears one cycle after
  // completion, and a new request may be taken two cycles after it).
  bit           use_model = 1'b1;
  bit           m_pend;
  bit           m_abort;
  bit           m_res_ok;
  logic [15:0]  m_op;
  logic [63:0]  m_wdata;
  logic [63:0]  m_res;
  int           m_since;
  int           m_wait;

  task automatic model_reset();
    m_pend = 0; m_abort = 0; m_res_ok = 0; m_op = '0; m_wdata = '0;
    m_res = '0; m_since = 100; m_wait = 0;
  endtask

  task automatic step(input bit v, input logic [15:0] op, input logic [63:0] wd,
                      input bit fl, input bit cm, input logic [127:0] rd);
    bit e_busy, e_rdy, e_vld, done_now;
    cp0_l2csr_req_vld = v; cp0_l2csr_req_op = op; cp0_l2csr_req_wdata = wd;
    cp0_l2csr_flush = fl; biu_csr_cmplt = cm; biu_csr_rdata = rd;
    @(negedge coreclk);
    s_sel = biu_csr_sel; s_busy = l2csr_busy; s_rdy = l2csr_req_rdy; s_vld = l2csr_rslt_vld;
    s_err = l2csr_rslt_err; s_data = l2csr_rslt_data; s_op = biu_csr_op; s_wdata = biu_csr_wdata;
    e_busy = m_pend || (m_since == 1);
    e_rdy  = !e_busy && !fl;
    e_vld  = (m_since == 1) && m_res_ok;
    if (use_model) begin
      chk("m_sel", s_sel, m_pend);
      chk("m_busy", s_busy, e_busy);
      chk("m_rdy", s_rdy, e_rdy);
      chk("m_rslt_vld", s_vld, e_vld);
      chk("m_rslt_err", s_err, 1'b0);
      if (e_vld) chk("m_rslt_data", s_data, m_res);
      if (m_pend) begin
        chk("m_biu_op", s_op, m_op);
        chk("m_biu_wdata", s_wdata, m_wdata);
      end
    end
    done_now = 0;
    if (e_rdy && v) begin
      m_pend = 1; m_op = op; m_wdata = wd; m_abort = 0; m_wait = 0;
    end else if (m_pend) begin
      m_wait++;
      if (cm) begin
        m_pend = 0; done_now = 1;
        m_res_ok = !m_abort && !fl;
        m_res = m_op[15] ? rd[127:64] : rd[63:0];
      end else if (fl) begin
        m_abort = 1;
      end
    end
    m_since = done_now ? 1 : (m_since < 100 ? m_since + 1 : 100);
    @(posedge coreclk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, 0, '0);
  endtask

  typedef struct {
    logic [15:0]  op;
    logic [63:0]  wdata;
    logic [127:0] rdata;
    int           lat;       // cycle of cmplt relative to acceptance
    int           flush_at;  // cycle of a flush pulse, 0 = none
    bit           exp_vld;
    logic [63:0]  exp_data;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [15:0] op_a, op_b;
    int tmo_vld_cnt, tmo_vld_cyc;
    logic tmo_err;
    logic [63:0] tmo_data;

    vecs[0] = '{16'h8012, 64'h5, {64'hAAAA, 64'hBBBB}, 6, 0, 1'b1, 64'hAAAA};
    vecs[1] = '{16'h0012, 64'h7, {64'hAAAA, 64'hBBBB}, 1, 0, 1'b1, 64'hBBBB};
    vecs[2] = '{16'h8001, 64'h9, {64'h1111, 64'h2222}, 5, 3, 1'b0, 64'h0};
    vecs[3] = '{16'h0003, 64'hA, {64'h3333, 64'h4444}, 2, 2, 1'b0, 64'h0};
    vecs[4] = '{16'h7FFF, 64'hDEAD_BEEF, {64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321},
                3, 0, 1'b1, 64'h0FED_CBA9_8765_4321};

    model_reset();
    #2;
    chk("rst_sel", biu_csr_sel, 1'b0);
    chk("rst_busy", l2csr_busy, 1'b0);
    chk("rst_rslt_vld", l2csr_rslt_vld, 1'b0);
    chk("rst_rslt_err", l2csr_rslt_err, 1'b0);
    chk("rst_rslt_data", l2csr_rslt_data, 64'd0);
    chk("rst_biu_op", biu_csr_op, 16'd0);
    chk("rst_biu_wdata", biu_csr_wdata, 64'd0);
    @(negedge coreclk); cpurst_b = 1'b1;
    @(posedge coreclk); #1;
    idle(2);

    // Table-driven single transactions.
    for (int k = 0; k < 5; k++) begin
      step(1, vecs[k].op, vecs[k].wdata, 0, 0, '0);
      chk("vec_accept_rdy", s_rdy, 1'b1);
      for (int c = 1; c <= vecs[k].lat; c++) begin
        step(0, '0, '0, c == vecs[k].flush_at, c == vecs[k].lat,
             c == vecs[k].lat ? vecs[k].rdata : ~vecs[k].rdata);
        chk("vec_sel_high", s_sel, 1'b1);
        chk("vec_biu_op", s_op, vecs[k].op);
      end
      step(0, '0, '0, 0, 0, '0);
      chk("vec_sel_low", s_sel, 1'b0);
      chk("vec_rslt_vld", s_vld, vecs[k].exp_vld);
      if (vecs[k].exp_vld) chk("vec_rslt_data", s_data, vecs[k].exp_data);
      step(0, '0, '0, 0, 0, '0);
      chk("vec_rdy_after_gap", s_rdy, 1'b1);
    end

    // Back-to-back: second request held from cycle 1, first cmplt at cycle 4.
    op_a = 16'h0101; op_b = 16'h0202;
    step(1, op_a, 64'h11, 0, 0, '0);
    for (int c = 1; c <= 3; c++) begin
      step(1, op_b, 64'h22, 0, 0, '0);
      chk("b2b_op_held", s_op, op_a);
    end
    step(1, op_b, 64'h22, 0, 1, {64'h0, 64'h55});
    step(1, op_b, 64'h22, 0, 1, {64'h0, 64'h66});
    chk("b2b_sel_low5", s_sel, 1'b0);
    chk("b2b_rdy_low5", s_rdy, 1'b0);
    chk("b2b_vld5", s_vld, 1'b1);
    step(1, op_b, 64'h22, 0, 0, '0);
    chk("b2b_sel_low6", s_sel, 1'b0);
    chk("b2b_accept6", s_rdy, 1'b1);
    step(0, '0, '0, 0, 0, '0);
    chk("b2b_sel_rise7", s_sel, 1'b1);
    chk("b2b_op7", s_op, op_b);
    step(0, '0, '0, 0, 1, {64'h0, 64'h77});
    idle(2);

    // Flush coincident with a request in IDLE: not accepted.
    step(1, 16'h0055, 64'h1, 1, 0, '0);
    chk("flush_idle_rdy", s_rdy, 1'b0);
    step(0, '0, '0, 0, 0, '0);
    chk("flush_idle_busy", s_busy, 1'b0);
    chk("flush_idle_sel", s_sel, 1'b0);

    // Spurious cmplt in IDLE.
    step(0, '0, '0, 0, 1, {64'h9, 64'h9});
    step(0, '0, '0, 0, 0, '0);
    chk("spur_vld", s_vld, 1'b0);
    chk("spur_busy", s_busy, 1'b0);
    chk("spur_sel", s_sel, 1'b0);

    // Reset mid-WAIT, then a late cmplt.
    step(1, 16'h0ABC, 64'h3, 0, 0, '0);
    idle(2);
    cpurst_b = 1'b0;
    #1;
    chk("rstw_sel", biu_csr_sel, 1'b0);
    chk("rstw_busy", l2csr_busy, 1'b0);
    @(posedge coreclk);
    @(negedge coreclk); cpurst_b = 1'b1;
    model_reset();
    @(posedge coreclk); #1;
    step(0, '0, '0, 0, 1, {64'h5, 64'h5});
    step(0, '0, '0, 0, 0, '0);
    chk("rstw_late_vld", s_vld, 1'b0);
    chk("rstw_late_busy", s_busy, 1'b0);

`ifdef L2CSR_TIMEOUT_EN
    // Timeout after 8 WAIT cycles; the late cmplt yields no second result.
    use_model = 0;
    tmo_vld_cnt = 0; tmo_vld_cyc = -1; tmo_err = 0; tmo_data = '1;
    step(1, 16'h8100, 64'h4, 0, 0, '0);
    for (int c = 1; c <= 20; c++) begin
      step(0, '0, '0, 0, 0, {64'h1, 64'h2});
      chk("tmo_sel_held", s_sel, 1'b1);
      if (s_vld) begin
        tmo_vld_cnt++;
        tmo_vld_cyc = c; tmo_err = s_err; tmo_data = s_data;
      end
    end
    chk("tmo_vld_count", tmo_vld_cnt, 1);
    chk("tmo_vld_cycle", tmo_vld_cyc, 9);
    chk("tmo_err", tmo_err, 1'b1);
    chk("tmo_data", tmo_data, 64'd0);
    step(0, '0, '0, 0, 1, {64'h1, 64'h2});
    step(0, '0, '0, 0, 0, '0);
    chk("tmo_late_vld", s_vld, 1'b0);
    chk("tmo_late_sel", s_sel, 1'b0);
    step(0, '0, '0, 0, 0, '0);
    chk("tmo_rdy", s_rdy, 1'b1);
    use_model = 1;
`endif

    // Randomized traffic against the reference model.
    for (int i = 0; i < 800; i++) begin
      bit v, fl, cm;
      v  = ($urandom % 2) == 0;
      fl = ($urandom % 10) == 0;
      cm = (($urandom % 5) == 0) || (m_pend && m_wait >= 5);
      step(v, 16'($urandom), {$urandom, $urandom}, fl, cm,
           {$urandom, $urandom, $urandom, $urandom});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
